// File: rtl/e_pkg.sv
// e_pkg: shared types and limits for the e-cell run-pack encoder.
package e_pkg;
    localparam int W_MIN  = 2;
    localparam int W_MAX  = 8;
    localparam int NR_MAX = $clog2(W_MAX/2+1);

    typedef enum logic {EMPTY, ACCUM} state_e;

    typedef struct packed {
        logic [W_MAX-1:0] start;
        logic [W_MAX-1:0] stop;
        logic             flush;
    } run_desc_t;

    typedef struct packed {
        logic [W_MAX-1:0]  x;
        logic [W_MAX-1:0]  occ;
        logic [NR_MAX-1:0] nrun;
    } frame_t;
endpackage

// File: rtl/e_run_mask.sv
// e_run_mask: turns one-hot start/end positions into a run mask, its claimed bits and a malformed flag.
module e_run_mask #(
    parameter int W = 4
) (
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] e_i,
    output logic [W-1:0] mask_o,
    output logic [W-1:0] claim_o,
    output logic         bad_o
);
    logic [W-1:0] s_m1, e_m1;

    assign s_m1    = s_i - W'(1);
    assign e_m1    = e_i - W'(1);
    assign mask_o  = (s_i | s_m1) & ~(e_i | e_m1);
    assign claim_o = (s_i | s_m1) & ~e_m1;
    // e must sit strictly below s, i.e. inside s's lower thermometer
    assign bad_o   = !$onehot(s_i) | !$onehot(e_i) | ((e_i & s_m1) == '0);
endmodule

// File: rtl/e_run_pack.sv
// e_run_pack: packs run descriptors into run-bitmap frames, emitting on flush, full or overlap.
module e_run_pack
    import e_pkg::*;
#(
    parameter int W  = 4,
    parameter int NR = $clog2(W/2+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [W-1:0]  start_i,
    input  logic [W-1:0]  end_i,
    input  logic          flush_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [W-1:0]  out_x_o,
    output logic [W-1:0]  out_occ_o,
    output logic [NR-1:0] out_nrun_o,
    output logic          err_o
);
    state_e            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d, occ_q, occ_d, mask, claim, m_acc, m_occ;
    logic [NR-1:0]     cnt_q, cnt_d, m_cnt;
    logic [2*W+NR-1:0] out_q, out_d, pend_q, pend_d, old_f, new_f;
    logic              out_vld_q, out_vld_d, pend_vld_q, pend_vld_d, err_q, err_d;
    logic              bad, xfer, has_run, good, ovl, emit_new;

    e_run_mask #(.W(W)) u_mask (
        .s_i    (start_i),
        .e_i    (end_i),
        .mask_o (mask),
        .claim_o(claim),
        .bad_o  (bad)
    );

    always_comb begin
        xfer     = in_vld_i & ~out_vld_q;
        has_run  = xfer & (~flush_i | (|start_i));
        good     = has_run & ~bad;
        ovl      = good & (|(claim & occ_q));
        m_acc    = ovl ? mask : good ? (acc_q | mask) : acc_q;
        m_occ    = ovl ? claim : good ? (occ_q | claim) : occ_q;
        m_cnt    = ovl ? NR'(1) : good ? cnt_q + NR'(1) : cnt_q;
        emit_new = (&m_occ) | (xfer & flush_i & ((state_q == ACCUM) | good));
        old_f    = {acc_q, occ_q, cnt_q};
        new_f    = {m_acc, m_occ, m_cnt};
        acc_d    = emit_new ? '0 : m_acc;
        occ_d    = emit_new ? '0 : m_occ;
        cnt_d    = emit_new ? '0 : m_cnt;
        state_d  = (occ_d != '0) ? ACCUM : EMPTY;
        err_d    = has_run & bad;
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        // input is only accepted while the output stage is empty, so these never coincide
        if (out_vld_q & out_rdy_i) begin
            out_vld_d  = pend_vld_q;
            out_d      = pend_vld_q ? pend_q : out_q;
            pend_vld_d = 1'b0;
        end else if (ovl | emit_new) begin
            out_vld_d  = 1'b1;
            out_d      = ovl ? old_f : new_f;
            pend_vld_d = ovl & emit_new;
            pend_d     = new_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            acc_q      <= '0;
            occ_q      <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            pend_q     <= '0;
            out_vld_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            pend_q     <= pend_d;
            out_vld_q  <= out_vld_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    assign in_rdy_o                          = ~out_vld_q;
    assign out_vld_o                         = out_vld_q;
    assign {out_x_o, out_occ_o, out_nrun_o}  = out_q;
    assign err_o                             = err_q;
endmodule

// File: tb/tb_e_run_pack.sv
// tb_e_run_pack: directed and randomized checks of e_run_pack against a run-level reference model.
module tb_e_run_pack;
    localparam int W  = 4;
    localparam int NR = $clog2(W/2+1);
    localparam int FW = 2*W+NR;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_vld_i = 1'b0, flush_i = 1'b0, out_rdy_i = 1'b1;
    logic [W-1:0]  start_i = '0, end_i = '0;
    logic          in_rdy_o, out_vld_o, err_o;
    logic [W-1:0]  out_x_o, out_occ_o;
    logic [NR-1:0] out_nrun_o;

    int             n_asrt = 0, n_fail = 0;
    logic [FW-1:0]  exp_q[$];
    logic [W-1:0]   m_acc = '0, m_occ = '0;
    int             m_cnt = 0;
    logic           err_exp = 1'b0;
    bit             rand_rdy = 1'b0;
    logic [15:0]    f0;

    e_run_pack #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .start_i   (start_i),
        .end_i     (end_i),
        .flush_i   (flush_i),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .out_x_o   (out_x_o),
        .out_occ_o (out_occ_o),
        .out_nrun_o(out_nrun_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    function automatic int pos(logic [W-1:0] v);
        int p = -1, n = 0;
        for (int i = 0; i < W; i++) if (v[i]) begin p = i; n++; end
        return (n == 1) ? p : -1;
    endfunction

    // e_cell reference: walk down from the selected start over ones; the first zero is the end
    function automatic logic [W-1:0] ecell(logic [W-1:0] x, logic [W-1:0] sel);
        int i = pos(sel);
        while (i >= 0 && x[i]) i--;
        return (i >= 0) ? (W'(1) << i) : '0;
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(logic [W-1:0] s, logic [W-1:0] e, logic f);
        int ps = pos(s), pe = pos(e);
        logic run = !f || (s != '0);
        logic [W-1:0] mk = '0, cl = '0;
        err_exp = run && (ps < 0 || pe < 0 || pe >= ps);
        if (run && !err_exp) begin
            for (int i = pe; i <= ps; i++) begin
                cl[i] = 1'b1;
                if (i > pe) mk[i] = 1'b1;
            end
            if ((cl & m_occ) != '0) begin
                exp_q.push_back({m_acc, m_occ, NR'(m_cnt)});
                m_acc = mk; m_occ = cl; m_cnt = 1;
            end else begin
                m_acc |= mk; m_occ |= cl; m_cnt++;
            end
        end
        if (m_occ == '1 || (f && m_occ != '0)) begin
            exp_q.push_back({m_acc, m_occ, NR'(m_cnt)});
            m_acc = '0; m_occ = '0; m_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("err", 16'(err_o), 16'(err_exp));
        chk("in_rdy", 16'(in_rdy_o), 16'(exp_q.size() == 0));
        chk("out_vld", 16'(out_vld_o), 16'(exp_q.size() != 0));
        if (out_vld_o && exp_q.size() != 0)
            chk("frame", 16'({out_x_o, out_occ_o, out_nrun_o}), 16'(exp_q[0]));
        if (rst) begin
            exp_q.delete();
            m_acc = '0; m_occ = '0; m_cnt = 0; err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (out_vld_o && out_rdy_i) void'(exp_q.pop_front());
            if (in_vld_i && in_rdy_o) model(start_i, end_i, flush_i);
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_rdy_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(logic [W-1:0] s, logic [W-1:0] e, logic f);
        bit done = 1'b0;
        start_i = s; end_i = e; flush_i = f; in_vld_i = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            done = in_rdy_o;
            step();
        end
        in_vld_i = 1'b0; start_i = '0; end_i = '0; flush_i = 1'b0;
        chk("accept_timeout", 16'(done), 16'(1));
    endtask

    task automatic expf(string tag, logic [W-1:0] x, logic [W-1:0] occ, int n);
        chk(tag, 16'({out_vld_o, out_x_o, out_occ_o, out_nrun_o}), 16'({1'b1, x, occ, NR'(n)}));
    endtask

    initial begin
        logic [W-1:0] rs, re;
        logic rf;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("reset_state", 16'({out_vld_o, out_x_o, out_occ_o, out_nrun_o, err_o}), 16'(0));
        chk("reset_rdy", 16'(in_rdy_o), 16'(1));

        beat(4'b1000, 4'b0100, 1'b0);
        beat(4'b0010, 4'b0001, 1'b0);
        expf("auto_full", 4'b1010, 4'b1111, 2);
        step();

        beat(4'b1000, 4'b0010, 1'b0);
        beat(4'b0000, 4'b0000, 1'b1);
        expf("flush", 4'b1100, 4'b1110, 1);
        chk("ecell", 16'(ecell(out_x_o, 4'b1000)), 16'(4'b0010));
        step();

        beat(4'b1000, 4'b0010, 1'b0);
        beat(4'b0100, 4'b0001, 1'b0);
        expf("overlap_old", 4'b1100, 4'b1110, 1);
        step();
        beat(4'b0000, 4'b0000, 1'b1);
        expf("overlap_new", 4'b0110, 4'b0111, 1);
        step();

        beat(4'b1000, 4'b0010, 1'b0);
        beat(4'b0100, 4'b0100, 1'b0);
        chk("bad_eq_err", 16'({err_o, out_vld_o}), 16'(2'b10));
        beat(4'b1100, 4'b0001, 1'b0);
        chk("bad_hot_err", 16'({err_o, out_vld_o}), 16'(2'b10));
        beat(4'b0000, 4'b0000, 1'b1);
        expf("bad_kept_state", 4'b1100, 4'b1110, 1);
        step();

        out_rdy_i = 1'b0;
        beat(4'b1000, 4'b0100, 1'b0);
        beat(4'b0010, 4'b0001, 1'b0);
        f0 = 16'({out_vld_o, out_x_o, out_occ_o, out_nrun_o});
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_rdy", 16'(in_rdy_o), 16'(0));
            chk("bp_hold", 16'({out_vld_o, out_x_o, out_occ_o, out_nrun_o}), f0);
        end
        out_rdy_i = 1'b1;
        step();
        chk("bp_release", 16'(in_rdy_o), 16'(1));

        beat(4'b1000, 4'b0010, 1'b0);
        beat(4'b0100, 4'b0001, 1'b1);
        expf("two_first", 4'b1100, 4'b1110, 1);
        step();
        expf("two_second", 4'b0110, 4'b0111, 1);
        chk("two_rdy", 16'(in_rdy_o), 16'(0));
        step();
        chk("two_done", 16'(in_rdy_o), 16'(1));

        out_rdy_i = 1'b0;
        beat(4'b1000, 4'b0010, 1'b0);
        beat(4'b0100, 4'b0001, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pending", 16'({out_vld_o, out_x_o, out_occ_o, out_nrun_o, err_o}), 16'(0));
        out_rdy_i = 1'b1;
        beat(4'b0000, 4'b0000, 1'b1);
        chk("rst_flush_empty", 16'(out_vld_o), 16'(0));
        step();

        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) step();
            else begin
                rs = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'(1) << $urandom_range(0, W-1);
                re = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'(1) << $urandom_range(0, W-1);
                rf = ($urandom_range(0, 4) == 0);
                if (rf && $urandom_range(0, 1) == 1) rs = '0;
                beat(rs, re, rf);
            end
        end
        rand_rdy = 1'b0;
        out_rdy_i = 1'b1;
        beat(4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        step();
        chk("drained", 16'(out_vld_o), 16'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/e_run_pack.md
Name: e_run_pack

Overview:
- Run encoder for the e-cell run format. e_cell finds the end of a run; this block works in the other direction and builds a run-bitmap frame from a stream of run descriptors.
- Each descriptor is a pair of one-hot vectors: a start position and an end position. The descriptor becomes a run of ones that begins at the start bit and walks toward bit 0, closed by a zero at the end bit.
- Descriptors accumulate into a W-bit frame. The frame is emitted over a valid/ready interface when it is flushed, full, or hit by an overlapping run.
- Consistency rule: every emitted frame, scanned by e_cell with the start of each packed run as the select, returns that run's end one-hot.

Parameters:
W  4  frame width in bits; supported range 2..8; bit W-1 is scanned first.
NR  $clog2(W/2+1)  derived; width of the run-count output.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_vld_i  input  1  descriptor or flush valid
in_rdy_o  output  1  block can accept
start_i  input  W  one-hot run start position s
end_i  input  W  one-hot run end position e (terminating zero)
flush_i  input  1  with in_vld_i: emit the accumulated frame; if start_i is nonzero, a run is packed first
out_vld_o  output  1  frame valid
out_rdy_i  input  1  downstream accept
out_x_o  output  W  frame bitmap
out_occ_o  output  W  claimed-bit mask of the frame
out_nrun_o  output  NR  number of runs packed in the frame
err_o  output  1  one-cycle pulse: malformed descriptor dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: out_vld_o=0, out_x_o=0, out_occ_o=0, out_nrun_o=0, err_o=0. Internal acc, occ and cnt are cleared; state goes to EMPTY.
  - Reset overrides any handshake in the same cycle.
  - A frame still pending on the output is discarded.
- Handshakes:
  - Transfer on the input when in_vld_i & in_rdy_o.
  - Transfer on the output when out_vld_o & out_rdy_i.
  - in_rdy_o = !out_vld_o. No combinational path from out_rdy_i to in_rdy_o.
- Run mask for a descriptor with start position s and end position e:
  - Bits e+1..s are set to 1; bit e is 0.
  - Claimed bits are e..s inclusive.
- Malformed descriptor: start_i or end_i not one-hot, or e >= s.
  - The descriptor is dropped and err_o pulses on the next cycle.
  - An accompanying flush_i is still honoured.
- States: EMPTY (occ==0), ACCUM (occ!=0). The output register is a separate 1-entry holding stage; while it holds a frame, in_rdy_o=0.
- Accepted non-overlapping run (claim & occ == 0):
  - acc |= mask, occ |= claim, cnt += 1; next state ACCUM.
  - If the new occ is all-ones, the frame is emitted in the same update. out_* are loaded next cycle and acc/occ/cnt are cleared to EMPTY.
- Accepted overlapping run (claim & occ != 0):
  - The current acc/occ/cnt are loaded into the output register.
  - In the same cycle the new run is loaded as a fresh frame: acc=mask, occ=claim, cnt=1.
- Flush:
  - An accepted flush_i in ACCUM emits the frame, after packing any valid run carried in the same beat.
  - A flush in EMPTY with no run produces no output.
  - Run and flush in the same beat with an overlap emits two frames. The older frame goes first; the run's frame is retained as pending and emitted after the first output transfer. in_rdy_o stays 0 until both have left.
- Latency: out_vld_o rises one cycle after the triggering input transfer.
- Output stability: out_x_o, out_occ_o and out_nrun_o hold stable while out_vld_o & !out_rdy_i.
- Width rule: cnt saturates at W/2 by construction (each run claims at least 2 bits); no wrap occurs.

Decomposition:
- Shared package e_pkg holds:
  - the run-descriptor struct (start, end, flush);
  - frame struct (x, occ, nrun);
  - the state enum {EMPTY, ACCUM};
  - localparams for the supported W range.
- Sub-module e_run_mask: combinational. Takes one-hot s and e; produces mask, claim and malformed flag. Uses a thermometer from s AND NOT a thermometer from e.
- Everything else lives in e_run_pack.

Test Plan:
- W=4, run s=1000 e=0100 then s=0010 e=0001 -> a single frame out_x_o=1010, out_occ_o=1111, out_nrun_o=2, one cycle after the second transfer (auto-full emit).
- W=4, run s=1000 e=0010, then flush-only beat -> out_x_o=1100, out_occ_o=1110, nrun=1. Check with e_cell: sel=1000 on 1100 gives y=0010.
- W=4, run s=1000 e=0010 then run s=0100 e=0001 (overlap) -> frame 1100/1110/1 emitted; the next flush emits 0110/0111/1.
- Malformed s=0100 e=0100 -> err_o pulse one cycle later, no frame, state unchanged; s=1100 e=0001 -> same.
- Backpressure: hold out_rdy_i=0 for 5 cycles after an emit -> in_rdy_o=0 and out_* stable throughout; release -> in_rdy_o=1 the cycle after the transfer.
- Assert rst while ACCUM with a frame pending on the output -> all outputs 0 next cycle; a following flush produces no frame.
